hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Execute-stage producer of the HI/LO register write interface.
- Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO operations and computes the HI/LO results.
- Multiply and move operations finish in a single cycle.
- Divide is a multi-cycle restoring divider, and the block stalls the pipeline while it runs.
- Outputs are registered and drive the write-enable and write-data pairs consumed by the write-back HI/LO registers.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width.
- DIV_CYCLES, DATA_WIDTH, iteration count. It is fixed at one quotient bit per cycle and is not user-overridable in practice.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  operation presented this cycle.
- op_code  input  3  operation code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is reserved and treated as NOP.
- operand_a  input  DATA_WIDTH  rs value; dividend, multiplicand, or MTHI/MTLO source.
- operand_b  input  DATA_WIDTH  rt value; divisor or multiplier.
- cancel  input  1  pipeline flush; aborts any pending operation.
- stall_request  output  1  freeze upstream pipeline (combinational).
- busy  output  1  divider state not IDLE (registered).
- register_hi_write_enable  output  1  HI write strobe.
- register_hi_write_data  output  DATA_WIDTH  HI value.
- register_lo_write_enable  output  1  LO write strobe.
- register_lo_write_data  output  DATA_WIDTH  LO value.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All write enables are 0, all data outputs are 0, and busy is 0.
  - The divider datapath is cleared.
  - Reset overrides any in-flight divide; no write results from it.
- States: IDLE, DIV_RUN, DIV_DONE.
- IDLE:
  - An operation is accepted when op_valid=1, cancel=0 and op_code is non-NOP.
  - MULT/MULTU: the full 2*DATA_WIDTH product is registered. At T+1, both enables are 1, HI gets the upper half and LO the lower half. MULT is signed; MULTU is unsigned.
  - MTHI: at T+1, only the HI enable is 1 and HI data = operand_a. LO enable is 0 and LO data holds its previous value.
  - MTLO: the mirror of MTHI.
  - DIV/DIVU:
    - Latch the operand magnitudes. For DIV, take the absolute values and record the quotient sign (a XOR b) and the remainder sign (sign of a).
    - Go to DIV_RUN with the iteration counter at 0.
    - stall_request=1 combinationally in cycle T.
- DIV_RUN:
  - Each cycle, shift one dividend bit into the partial remainder, subtract the divisor, and restore if the result is negative.
  - The counter increments each cycle. After DIV_CYCLES iterations (cycles T+1..T+32), go to DIV_DONE.
  - stall_request=1 throughout.
- DIV_DONE (cycle T+33):
  - Apply sign correction by two's complement, then pulse both enables for one cycle: HI = remainder, LO = quotient.
  - stall_request=0 in this cycle, so the pipeline resumes on the same edge that writes HI/LO.
  - Return to IDLE.
- Divide by zero:
  - No iteration. Go IDLE -> DIV_DONE directly, so results appear at T+1 and stall_request=1 only in cycle T.
  - Result: LO = all ones, HI = operand_a unmodified (signed and unsigned alike).
- Signed overflow (0x80000000 / -1): handled by the magnitude path. Result is LO = 0x80000000, HI = 0.
- Write enables are single-cycle pulses. They are 0 in every cycle without a completing operation.
- Data outputs hold their last value when the enables are 0.
- cancel:
  - In any state, cancel returns the block to IDLE the next cycle. It suppresses all write enables in that next cycle and stall_request drops to 0 combinationally.
  - cancel together with op_valid in IDLE means the operation is not accepted.
  - cancel in DIV_DONE suppresses the pulse.
- op_valid while busy is ignored; the stalled upstream keeps the op held.
- Back-to-back single-cycle ops are accepted every cycle at full throughput.

Decomposition:
- Shared package holds:
  - the op_code constants (HILO_OP_NOP..HILO_OP_MTLO);
  - the state encodings;
  - DATA_WIDTH default.
- One sub-module, hilo_divider: the iterative restoring core.
  - Ports: start, operands, signed flag, cancel, done, quotient, remainder.
  - The FSM, multiply and output registering stay in hilo_muldiv_unit.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> at T+1, both enables are 1, HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIVU a=100, b=7 -> stall_request high for cycles T..T+32, and at T+33 exactly one pulse with LO=14, HI=2; busy falls at T+34.
- DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV a=0x1234, b=0 -> results at T+1 with LO=0xFFFFFFFF, HI=0x1234, and stall only in cycle T.
- MTHI 0xAAAA5555 followed next cycle by MTLO 0x0F0F0F0F -> HI-only pulse at T+1 and LO-only pulse at T+2, with the other enable 0 in each cycle.
- DIVU started, cancel asserted at T+10 -> IDLE at T+11, no write enable ever; reset asserted at T+5 of a fresh divide -> all outputs 0 next cycle, no write.

Source files
------------

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// controller state encoding and the default datapath width.
package hilo_muldiv_unit_pkg;

    localparam int HILO_DATA_WIDTH = 32;

    localparam logic [2:0] HILO_OP_NOP   = 3'd0;
    localparam logic [2:0] HILO_OP_MULT  = 3'd1;
    localparam logic [2:0] HILO_OP_MULTU = 3'd2;
    localparam logic [2:0] HILO_OP_DIV   = 3'd3;
    localparam logic [2:0] HILO_OP_DIVU  = 3'd4;
    localparam logic [2:0] HILO_OP_MTHI  = 3'd5;
    localparam logic [2:0] HILO_OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        HILO_ST_IDLE     = 2'd0,
        HILO_ST_DIV_RUN  = 2'd1,
        HILO_ST_DIV_DONE = 2'd2
    } hilo_state_e;

endpackage

// File: rtl/hilo_divider.sv
// Iterative restoring divider, one quotient bit per cycle. Works on operand
// magnitudes and applies the recorded signs to the final step's result.
// done_o is high in the cycle whose clock edge completes the last iteration;
// quotient_o/remainder_o are valid (sign-corrected) while done_o is high.
module hilo_divider #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_CYCLES = DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic                  cancel_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] v);
        return ~v + ONE;
    endfunction

    logic                  running_q, running_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;

    logic                  a_neg_s, b_neg_s;
    logic [DATA_WIDTH:0]   shifted_s, diff_s;
    logic [DATA_WIDTH-1:0] rem_step_s, quo_step_s;

    assign a_neg_s = signed_i & dividend_i[DATA_WIDTH-1];
    assign b_neg_s = signed_i & divisor_i[DATA_WIDTH-1];

    // Trial subtraction: bring in the next dividend bit, keep the difference if non-negative.
    assign shifted_s  = {rem_q, quo_q[DATA_WIDTH-1]};
    assign diff_s     = shifted_s - {1'b0, dvsr_q};
    assign rem_step_s = diff_s[DATA_WIDTH] ? shifted_s[DATA_WIDTH-1:0] : diff_s[DATA_WIDTH-1:0];
    assign quo_step_s = {quo_q[DATA_WIDTH-2:0], ~diff_s[DATA_WIDTH]};

    assign done_o      = running_q & (cnt_q == LAST_CNT);
    assign quotient_o  = q_neg_q ? negate(quo_step_s) : quo_step_s;
    assign remainder_o = r_neg_q ? negate(rem_step_s) : rem_step_s;

    // Next-state: load magnitudes on start, iterate while running, stop on cancel.
    always_comb begin
        running_d = running_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        if (cancel_i) begin
            running_d = 1'b0;
        end else if (start_i) begin
            running_d = 1'b1;
            cnt_d     = {CW{1'b0}};
            rem_d     = {DATA_WIDTH{1'b0}};
            quo_d     = a_neg_s ? negate(dividend_i) : dividend_i;
            dvsr_d    = b_neg_s ? negate(divisor_i) : divisor_i;
            q_neg_d   = a_neg_s ^ b_neg_s;
            r_neg_d   = a_neg_s;
        end else if (running_q) begin
            rem_d     = rem_step_s;
            quo_d     = quo_step_s;
            cnt_d     = cnt_q + CNT_ONE;
            running_d = (cnt_q != LAST_CNT);
        end else begin
            running_d = 1'b0;
        end
    end

    // Divider state registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            running_q <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            rem_q     <= {DATA_WIDTH{1'b0}};
            quo_q     <= {DATA_WIDTH{1'b0}};
            dvsr_q    <= {DATA_WIDTH{1'b0}};
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
        end else begin
            running_q <= running_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Execute-stage HI/LO producer: single-cycle multiply and moves, multi-cycle
// divide with pipeline stall. Write strobes and data are registered and feed
// the write-back HI/LO registers directly.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = HILO_DATA_WIDTH,
    parameter int DIV_CYCLES = DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  op_valid,
    input  logic [2:0]            op_code,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  cancel,
    output logic                  stall_request,
    output logic                  busy,
    output logic                  register_hi_write_enable,
    output logic [DATA_WIDTH-1:0] register_hi_write_data,
    output logic                  register_lo_write_enable,
    output logic [DATA_WIDTH-1:0] register_lo_write_data
);

    localparam int PW = 2 * DATA_WIDTH;

    hilo_state_e           state_q, state_d;
    logic                  busy_q;
    logic                  hi_we_q, hi_we_d;
    logic                  lo_we_q, lo_we_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;

    logic [PW-1:0]         prod_signed_s, prod_unsigned_s;
    logic                  accept_s, is_div_s, div_signed_s, divisor_zero_s;
    logic                  div_start_s, div_done_s;
    logic [DATA_WIDTH-1:0] div_quo_s, div_rem_s;

    // Sign-extended operands give the signed product in the low 2*W bits.
    assign prod_signed_s   = {{DATA_WIDTH{operand_a[DATA_WIDTH-1]}}, operand_a}
                           * {{DATA_WIDTH{operand_b[DATA_WIDTH-1]}}, operand_b};
    assign prod_unsigned_s = {{DATA_WIDTH{1'b0}}, operand_a} * {{DATA_WIDTH{1'b0}}, operand_b};

    assign accept_s       = op_valid & ~cancel & (state_q == HILO_ST_IDLE);
    assign is_div_s       = (op_code == HILO_OP_DIV) | (op_code == HILO_OP_DIVU);
    assign div_signed_s   = (op_code == HILO_OP_DIV);
    assign divisor_zero_s = (operand_b == {DATA_WIDTH{1'b0}});

    // Stall while a divide is being accepted or iterating; DIV_DONE lets the pipe advance.
    assign stall_request = ~cancel & ((accept_s & is_div_s) | (state_q == HILO_ST_DIV_RUN));

    hilo_divider #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_divider (
        .clock       (clock),
        .reset       (reset),
        .start_i     (div_start_s),
        .signed_i    (div_signed_s),
        .cancel_i    (cancel),
        .dividend_i  (operand_a),
        .divisor_i   (operand_b),
        .done_o      (div_done_s),
        .quotient_o  (div_quo_s),
        .remainder_o (div_rem_s)
    );

    // Controller next-state and next output values; strobes default low every cycle.
    always_comb begin
        state_d     = state_q;
        hi_we_d     = 1'b0;
        lo_we_d     = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        div_start_s = 1'b0;
        if (cancel) begin
            state_d = HILO_ST_IDLE;
        end else begin
            case (state_q)
                HILO_ST_IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            HILO_OP_NOP: begin
                                state_d = HILO_ST_IDLE;
                            end
                            HILO_OP_MULT: begin
                                hi_we_d = 1'b1;
                                lo_we_d = 1'b1;
                                hi_d    = prod_signed_s[PW-1:DATA_WIDTH];
                                lo_d    = prod_signed_s[DATA_WIDTH-1:0];
                            end
                            HILO_OP_MULTU: begin
                                hi_we_d = 1'b1;
                                lo_we_d = 1'b1;
                                hi_d    = prod_unsigned_s[PW-1:DATA_WIDTH];
                                lo_d    = prod_unsigned_s[DATA_WIDTH-1:0];
                            end
                            HILO_OP_DIV, HILO_OP_DIVU: begin
                                if (divisor_zero_s) begin
                                    // No iteration: quotient all ones, remainder is the dividend.
                                    state_d = HILO_ST_DIV_DONE;
                                    hi_we_d = 1'b1;
                                    lo_we_d = 1'b1;
                                    hi_d    = operand_a;
                                    lo_d    = {DATA_WIDTH{1'b1}};
                                end else begin
                                    state_d     = HILO_ST_DIV_RUN;
                                    div_start_s = 1'b1;
                                end
                            end
                            HILO_OP_MTHI: begin
                                hi_we_d = 1'b1;
                                hi_d    = operand_a;
                            end
                            HILO_OP_MTLO: begin
                                lo_we_d = 1'b1;
                                lo_d    = operand_a;
                            end
                            default: begin
                                state_d = HILO_ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_d = HILO_ST_IDLE;
                    end
                end
                HILO_ST_DIV_RUN: begin
                    if (div_done_s) begin
                        state_d = HILO_ST_DIV_DONE;
                        hi_we_d = 1'b1;
                        lo_we_d = 1'b1;
                        hi_d    = div_rem_s;
                        lo_d    = div_quo_s;
                    end else begin
                        state_d = HILO_ST_DIV_RUN;
                    end
                end
                HILO_ST_DIV_DONE: begin
                    state_d = HILO_ST_IDLE;
                end
                default: begin
                    state_d = HILO_ST_IDLE;
                end
            endcase
        end
    end

    // Controller state and registered outputs with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= HILO_ST_IDLE;
            busy_q  <= 1'b0;
            hi_we_q <= 1'b0;
            lo_we_q <= 1'b0;
            hi_q    <= {DATA_WIDTH{1'b0}};
            lo_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != HILO_ST_IDLE);
            hi_we_q <= hi_we_d;
            lo_we_q <= lo_we_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy                     = busy_q;
    assign register_hi_write_enable = hi_we_q;
    assign register_hi_write_data   = hi_q;
    assign register_lo_write_enable = lo_we_q;
    assign register_lo_write_data   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: the driver pushes expected HI/LO
// writes (value and cycle) computed with plain arithmetic; a negedge monitor
// pops and compares every write strobe the DUT produces.
module tb_hilo_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        cancel;
    logic        stall_request;
    logic        busy;
    logic        hi_we;
    logic [31:0] hi_data;
    logic        lo_we;
    logic [31:0] lo_data;

    typedef struct {
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    logic [31:0] model_hi = 32'h0;
    logic [31:0] model_lo = 32'h0;

    hilo_muldiv_unit dut (
        .clock                    (clock),
        .reset                    (reset),
        .op_valid                 (op_valid),
        .op_code                  (op_code),
        .operand_a                (operand_a),
        .operand_b                (operand_b),
        .cancel                   (cancel),
        .stall_request            (stall_request),
        .busy                     (busy),
        .register_hi_write_enable (hi_we),
        .register_hi_write_data   (hi_data),
        .register_lo_write_enable (lo_we),
        .register_lo_write_data   (lo_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: compute the HI/LO write an accepted op must produce.
    task automatic push_expect(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b, input int t);
        exp_t e;
        longint sa, sb, p;
        longint unsigned ua, ub, pu;
        int sa32, sb32;
        bit has = 1'b1;
        e.hi_we = 1'b1; e.lo_we = 1'b1; e.hi = model_hi; e.lo = model_lo; e.cyc = t + 1;
        case (code)
            3'd1: begin
                sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b}; p = sa * sb;
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            3'd2: begin
                ua = {32'h0, a}; ub = {32'h0, b}; pu = ua * ub;
                e.hi = pu[63:32]; e.lo = pu[31:0];
            end
            3'd3, 3'd4: begin
                if (b == 32'h0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = a;
                end else begin
                    e.cyc = t + 33;
                    if (code == 3'd4) begin
                        e.lo = a / b; e.hi = a % b;
                    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        e.lo = 32'h8000_0000; e.hi = 32'h0;
                    end else begin
                        sa32 = a; sb32 = b;
                        e.lo = sa32 / sb32; e.hi = sa32 % sb32;
                    end
                end
            end
            3'd5: begin e.lo_we = 1'b0; e.hi = a; end
            3'd6: begin e.hi_we = 1'b0; e.lo = a; end
            default: has = 1'b0;
        endcase
        if (has) begin
            model_hi = e.hi; model_lo = e.lo;
            exp_q.push_back(e);
        end
    endtask

    // Present one op as an upstream stage would: hold it while stall_request is high.
    task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        int  stalls = 0;
        int  exp_stalls;
        bit  s;
        op_valid = 1'b1; op_code = code; operand_a = a; operand_b = b;
        push_expect(code, a, b, cyc);
        exp_stalls = ((code == 3'd3 || code == 3'd4) ? ((b == 32'h0) ? 1 : 33) : 0);
        forever begin
            @(negedge clock);
            s = stall_request;
            @(posedge clock); #1;
            if (!s) break;
            stalls++;
            if (stalls > 100) break;
        end
        check($sformatf("stall_cycles op%0d", code), 64'(stalls), 64'(exp_stalls));
    endtask

    // Monitor: every write strobe must match the next expected write, value and cycle.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && (hi_we || lo_we)) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: cyc=%0d hi_we=%b lo_we=%b hi=%h lo=%h required no write",
                         cyc, hi_we, lo_we, hi_data, lo_data);
            end else begin
                e = exp_q.pop_front();
                if (hi_we === e.hi_we && lo_we === e.lo_we && hi_data === e.hi &&
                    lo_data === e.lo && cyc == e.cyc) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL write: got cyc=%0d we=%b%b hi=%h lo=%h required cyc=%0d we=%b%b hi=%h lo=%h",
                             cyc, hi_we, lo_we, hi_data, lo_data, e.cyc, e.hi_we, e.lo_we, e.hi, e.lo);
                end
            end
        end
    end

    task automatic idle(input int n);
        op_valid = 1'b0; op_code = 3'd0;
        repeat (n) begin @(posedge clock); #1; end
    endtask

    initial begin
        logic [2:0]  rc;
        logic [31:0] ra, rb;
        reset = 1'b1; op_valid = 1'b0; op_code = 3'd0; operand_a = 32'h0; operand_b = 32'h0; cancel = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_hi_we", 64'(hi_we), 64'd0);
        check("reset_lo_we", 64'(lo_we), 64'd0);
        check("reset_hi", 64'(hi_data), 64'd0);
        check("reset_lo", 64'(lo_data), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        run_op(3'd1, 32'hFFFF_FFFE, 32'h3);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd4, 32'd100, 32'd7);
        op_valid = 1'b0;
        @(negedge clock);
        check("busy_after_divu", 64'(busy), 64'd0);
        @(posedge clock); #1;
        run_op(3'd3, 32'hFFFF_FFF9, 32'h2);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd3, 32'h0000_1234, 32'h0);
        run_op(3'd5, 32'hAAAA_5555, 32'h0);
        run_op(3'd6, 32'h0F0F_0F0F, 32'h0);
        idle(2);

        // Cancel a running divide at T+10: no write, idle at T+11.
        op_valid = 1'b1; op_code = 3'd4; operand_a = 32'd1000; operand_b = 32'd3;
        repeat (10) begin @(posedge clock); #1; end
        check("busy_before_cancel", 64'(busy), 64'd1);
        cancel = 1'b1; op_valid = 1'b0;
        @(negedge clock);
        check("cancel_stall_drop", 64'(stall_request), 64'd0);
        @(posedge clock); #1;
        cancel = 1'b0;
        @(negedge clock);
        check("cancel_busy", 64'(busy), 64'd0);
        @(posedge clock); #1;
        idle(40);

        // Cancel together with op_valid in IDLE: op must not be accepted.
        op_valid = 1'b1; op_code = 3'd1; operand_a = 32'h5; operand_b = 32'h6; cancel = 1'b1;
        @(posedge clock); #1;
        cancel = 1'b0; op_valid = 1'b0;
        @(negedge clock);
        check("cancel_accept_hi_we", 64'(hi_we), 64'd0);
        @(posedge clock); #1;

        // Reset at T+5 of a divide: outputs cleared, no write.
        op_valid = 1'b1; op_code = 3'd4; operand_a = 32'd500; operand_b = 32'd5;
        repeat (5) begin @(posedge clock); #1; end
        reset = 1'b1; op_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        model_hi = 32'h0; model_lo = 32'h0;
        @(negedge clock);
        check("rst_mid_hi", 64'(hi_data), 64'd0);
        check("rst_mid_lo", 64'(lo_data), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_we", 64'({hi_we, lo_we}), 64'd0);
        @(posedge clock); #1;
        idle(40);

        // Randomized back-to-back traffic including corner operands.
        for (int i = 0; i < 60; i++) begin
            rc = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: ra = 32'h0;
                2: rb = 32'h0;
                3: rb = 32'hFFFF_FFFF;
                4: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(rc, ra, rb);
        end
        idle(5);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
